// File: rtl/rca_wb_sequencer_pkg.sv
// Shared types and defaults for the RCA grid writeback sequencer.
package rca_wb_sequencer_pkg;

  localparam int RCA_XLEN = 32;
  localparam int RCA_NWP  = 3;
  localparam int RCA_ID_W = 3;

  typedef enum logic [1:0] {
    WBS_IDLE,
    WBS_DRAIN,
    WBS_DONE
  } wb_seq_state_t;

  // One grid result as seen by a writeback scheduler
  typedef struct packed {
    logic [RCA_XLEN-1:0] data;
    logic [4:0]          rd;
    logic                en;
  } rca_wb_result_t;

  // x0 is hardwired zero, so an enabled write to it is dropped
  function automatic logic rd_writable(input logic en, input logic [4:0] rd);
    return en && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/rca_wb_priority_enc.sv
// Lowest-index-first priority encoder: mask -> one-hot, index, any.
module rca_wb_priority_enc #(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the one that sticks
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |mask;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rca_wb_sequencer.sv
// Serialises one RCA grid commit onto the single register-file writeback port.
module rca_wb_sequencer
  import rca_wb_sequencer_pkg::*;
#(
  parameter int XLEN            = RCA_XLEN,
  parameter int NUM_WRITE_PORTS = RCA_NWP,
  parameter int ID_W            = RCA_ID_W
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  commit_valid,
  output logic                                  commit_ready,
  input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]  commit_data,
  input  logic [NUM_WRITE_PORTS-1:0][4:0]       commit_rd,
  input  logic [NUM_WRITE_PORTS-1:0]            commit_en,
  input  logic [ID_W-1:0]                       commit_id,
  output logic                                  wb_valid,
  input  logic                                  wb_ack,
  output logic [XLEN-1:0]                       wb_data,
  output logic [4:0]                            wb_rd,
  output logic [ID_W-1:0]                       wb_id,
  output logic                                  done
);

  localparam int NWP   = NUM_WRITE_PORTS;
  localparam int IDX_W = (NWP > 1) ? $clog2(NWP) : 1;

  wb_seq_state_t              state;
  logic [NWP-1:0][XLEN-1:0]   cap_data;
  logic [NWP-1:0][4:0]        cap_rd;
  logic [NWP-1:0]             mask;     // results still owed, including the one on the port
  logic [NWP-1:0]             cur_oh;   // result currently presented on wb_*
  logic [NWP-1:0]             in_mask;
  logic [NWP-1:0]             sel_mask;
  logic [NWP-1:0]             enc_oh;
  logic [IDX_W-1:0]           enc_idx;
  logic                       enc_any;
  logic [XLEN-1:0]            nxt_data;
  logic [4:0]                 nxt_rd;

  // Writable ports of the incoming commit (enable and rd != x0)
  always_comb begin
    in_mask = '0;
    for (int i = 0; i < NWP; i++) in_mask[i] = rd_writable(commit_en[i], commit_rd[i]);
  end

  // In IDLE pick the first beat straight from the commit so it lands one cycle
  // after accept; while draining pick the beat after the one on the port.
  always_comb begin
    sel_mask = (state == WBS_IDLE) ? in_mask : (mask & ~cur_oh);
    nxt_data = (state == WBS_IDLE) ? commit_data[enc_idx] : cap_data[enc_idx];
    nxt_rd   = (state == WBS_IDLE) ? commit_rd[enc_idx]   : cap_rd[enc_idx];
  end

  rca_wb_priority_enc #(.N(NWP)) u_enc (
    .mask   (sel_mask),
    .onehot (enc_oh),
    .idx    (enc_idx),
    .any    (enc_any)
  );

  // Sequencer FSM with capture array and registered handshake / writeback outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WBS_IDLE;
      commit_ready <= 1'b1;
      wb_valid     <= 1'b0;
      done         <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_id        <= '0;
      cap_data     <= '0;
      cap_rd       <= '0;
      mask         <= '0;
      cur_oh       <= '0;
    end else begin
      case (state)
        WBS_IDLE: begin
          done <= 1'b0;
          if (commit_valid) begin
            cap_data     <= commit_data;
            cap_rd       <= commit_rd;
            mask         <= in_mask;
            cur_oh       <= enc_oh;
            wb_id        <= commit_id;
            commit_ready <= 1'b0;
            if (enc_any) begin
              state    <= WBS_DRAIN;
              wb_valid <= 1'b1;
              wb_data  <= nxt_data;
              wb_rd    <= nxt_rd;
            end else begin
              state <= WBS_DONE;
              done  <= 1'b1;
            end
          end
        end
        WBS_DRAIN: begin
          // Without an ack the presented beat holds unchanged
          if (wb_ack) begin
            mask <= sel_mask;
            if (enc_any) begin
              cur_oh  <= enc_oh;
              wb_data <= nxt_data;
              wb_rd   <= nxt_rd;
            end else begin
              cur_oh   <= '0;
              wb_valid <= 1'b0;
              done     <= 1'b1;
              state    <= WBS_DONE;
            end
          end
        end
        WBS_DONE: begin
          done         <= 1'b0;
          commit_ready <= 1'b1;
          state        <= WBS_IDLE;
        end
        default: begin
          state        <= WBS_IDLE;
          commit_ready <= 1'b1;
          wb_valid     <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule
